// File: rtl/loop_filter_gs.sv
// Second-order PI carrier-loop filter with acquisition/tracking gear shift,
// saturating integrator and output, hold/clear controls and an output strobe.
module loop_filter_gs #(
    parameter int DW         = 26,
    parameter int GW         = 4,
    parameter int UPD_PERIOD = 8,
    parameter int SW         = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] pd,
    input  logic [SW-1:0]        acq_c1_sh,
    input  logic [SW-1:0]        acq_c2_sh,
    input  logic [SW-1:0]        trk_c1_sh,
    input  logic [SW-1:0]        trk_c2_sh,
    input  logic [15:0]          gear_len,
    input  logic                 hold,
    input  logic                 clear_int,
    output logic signed [DW-1:0] frequency_df,
    output logic                 df_valid,
    output logic                 mode_trk,
    output logic                 sat_flag
);

    localparam int CW   = (UPD_PERIOD > 2) ? $clog2(UPD_PERIOD) : 1;
    localparam int SUMW = DW + GW;
    localparam int AW   = SUMW + 1;
    localparam logic signed [AW-1:0] MAX_A = $signed((AW'(1) << (DW - 1)) - AW'(1));
    localparam logic signed [AW-1:0] MIN_A = ~MAX_A;

    typedef enum logic {
        ACQ = 1'b0,
        TRK = 1'b1
    } gear_e;

    gear_e                 state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [SUMW-1:0] sum_q, sum_d;
    logic signed [DW-1:0]  pd_cap_q, pd_cap_d;
    logic signed [DW-1:0]  freq_q, freq_d;
    logic                  df_valid_q, df_valid_d;
    logic                  upd_pend_q, upd_pend_d;
    logic                  sat_q, sat_d;
    logic [15:0]           gear_cnt_q, gear_cnt_d;
    logic [SW-1:0]         c1_sh, c2_sh;
    logic signed [AW-1:0]  int_sum, out_sum;

    // Floor shift; any shift of DW or more collapses to the sign (0 or -1).
    function automatic logic signed [AW-1:0] shr_ext(input logic signed [DW-1:0] x,
                                                     input logic [SW-1:0] sh);
        logic signed [DW-1:0] r;
        if (int'(sh) >= DW) r = x[DW-1] ? '1 : '0;
        else                r = x >>> sh;
        return $signed({{(AW-DW){r[DW-1]}}, r});
    endfunction

    function automatic logic signed [AW-1:0] clamp(input logic signed [AW-1:0] v);
        if (v > MAX_A) return MAX_A;
        if (v < MIN_A) return MIN_A;
        return v;
    endfunction

    function automatic logic ovf(input logic signed [AW-1:0] v);
        return (v > MAX_A) || (v < MIN_A);
    endfunction

    always_comb begin
        c1_sh = (state_q == TRK) ? trk_c1_sh : acq_c1_sh;
        c2_sh = (state_q == TRK) ? trk_c2_sh : acq_c2_sh;
        int_sum = $signed({{(AW-SUMW){sum_q[SUMW-1]}}, sum_q}) + shr_ext(pd, c2_sh);
        out_sum = $signed({{(AW-SUMW){sum_q[SUMW-1]}}, sum_q}) + shr_ext(pd_cap_q, c1_sh);
    end

    always_comb begin
        cnt_d      = (cnt_q == CW'(UPD_PERIOD - 1)) ? '0 : cnt_q + CW'(1);
        state_d    = state_q;
        sum_d      = sum_q;
        pd_cap_d   = pd_cap_q;
        freq_d     = freq_q;
        df_valid_d = 1'b0;
        upd_pend_d = upd_pend_q;
        sat_d      = sat_q;
        gear_cnt_d = gear_cnt_q;

        if (cnt_q == '0) begin
            upd_pend_d = !hold;
            if (!hold) begin
                pd_cap_d = pd;
                sum_d    = SUMW'(clamp(int_sum));
                if (ovf(int_sum)) sat_d = 1'b1;
                if (state_q == ACQ) gear_cnt_d = gear_cnt_q + 16'd1;
            end
        end else if (cnt_q == CW'(1) && upd_pend_q) begin
            upd_pend_d = 1'b0;
            freq_d     = DW'(clamp(out_sum));
            df_valid_d = 1'b1;
            if (ovf(out_sum)) sat_d = 1'b1;
        end

        // The switch lands one edge after the count reaches gear_len, so the
        // output of the last acquisition update still uses acquisition gains.
        if (state_q == ACQ && gear_cnt_q >= gear_len) state_d = TRK;

        if (clear_int) begin
            sum_d = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ACQ;
            cnt_q      <= '0;
            sum_q      <= '0;
            pd_cap_q   <= '0;
            freq_q     <= '0;
            df_valid_q <= 1'b0;
            upd_pend_q <= 1'b0;
            sat_q      <= 1'b0;
            gear_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            pd_cap_q   <= pd_cap_d;
            freq_q     <= freq_d;
            df_valid_q <= df_valid_d;
            upd_pend_q <= upd_pend_d;
            sat_q      <= sat_d;
            gear_cnt_q <= gear_cnt_d;
        end
    end

    assign frequency_df = freq_q;
    assign df_valid     = df_valid_q;
    assign mode_trk     = (state_q == TRK);
    assign sat_flag     = sat_q;

endmodule

// File: tb/tb_loop_filter_gs.sv
// Scoreboard bench for loop_filter_gs: directed updates push expected outputs,
// a monitor pops and compares on every df_valid pulse.
module tb_loop_filter_gs;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [25:0] pd;
    logic [4:0]         acq_c1_sh, acq_c2_sh, trk_c1_sh, trk_c2_sh;
    logic [15:0]        gear_len;
    logic               hold, clear_int;
    logic signed [25:0] frequency_df;
    logic               df_valid, mode_trk, sat_flag;

    logic signed [25:0] exp_q[$];
    int                 n_pass = 0;
    int                 n_total = 0;
    int                 ph = 0;

    loop_filter_gs #(.DW(26), .GW(4), .UPD_PERIOD(8), .SW(5)) dut (
        .clk(clk), .rst(rst), .pd(pd),
        .acq_c1_sh(acq_c1_sh), .acq_c2_sh(acq_c2_sh),
        .trk_c1_sh(trk_c1_sh), .trk_c2_sh(trk_c2_sh),
        .gear_len(gear_len), .hold(hold), .clear_int(clear_int),
        .frequency_df(frequency_df), .df_valid(df_valid),
        .mode_trk(mode_trk), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Reference update phase: 0 right after reset, then counts modulo 8.
    always @(posedge clk) begin
        if (!rst) ph <= 0;
        else      ph <= (ph + 1) % 8;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic set_coef(input int a1, input int a2, input int t1, input int t2, input int gl);
        acq_c1_sh = 5'(a1); acq_c2_sh = 5'(a2);
        trk_c1_sh = 5'(t1); trk_c2_sh = 5'(t2);
        gear_len  = 16'(gl);
    endtask

    task automatic do_reset();
        rst = 1'b0; hold = 1'b1; clear_int = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic upd();
        hold = 1'b0;
        while (ph != 0) @(negedge clk);
        @(negedge clk);
        hold = 1'b1;
    endtask

    task automatic upd_clr();
        hold = 1'b0;
        while (ph != 0) @(negedge clk);
        clear_int = 1'b1;
        @(negedge clk);
        clear_int = 1'b0;
        hold = 1'b1;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic push(input longint v);
        exp_q.push_back(26'(v));
    endtask

    initial begin
        rst = 1'b0; hold = 1'b1; clear_int = 1'b0; pd = '0;
        set_coef(0, 0, 0, 0, 0);
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (df_valid) begin
                        chk("df_valid_phase", ph, 2);
                        if (exp_q.size() == 0) chk("unexpected_df_valid", 1, 0);
                        else chk("frequency_df", frequency_df, exp_q.pop_front());
                    end
                end
            end
            begin : stimulus
                // Constant gain, gear_len 0, plus reset state
                set_coef(6, 13, 6, 13, 0); pd = 26'sd8192;
                rst = 1'b0; hold = 1'b1;
                repeat (2) @(negedge clk);
                chk("rst_freq", frequency_df, 0);
                chk("rst_valid", df_valid, 0);
                chk("rst_mode", mode_trk, 0);
                chk("rst_sat", sat_flag, 0);
                rst = 1'b1;
                for (int i = 0; i < 4; i++) begin push(129 + i); upd(); end
                settle();
                chk("gear0_mode", mode_trk, 1);

                // Negative floor
                do_reset(); pd = -26'sd1;
                for (int i = 0; i < 3; i++) begin push(-2 - i); upd(); end
                settle();

                // Gear shift
                do_reset(); set_coef(5, 12, 10, 17, 3); pd = 26'sd131072;
                push(4128); upd(); settle();
                push(4160); upd(); settle();
                chk("gear_mode_acq", mode_trk, 0);
                push(4192); upd(); settle();
                chk("gear_mode_trk", mode_trk, 1);
                push(225); upd(); settle();
                push(226); upd(); settle();

                // Saturation and clear of sat_flag
                do_reset(); set_coef(0, 0, 0, 0, 0); pd = 26'sd33554431;
                push(33554431); upd();
                push(33554431); upd(); settle();
                chk("sat_set", sat_flag, 1);
                clear_int = 1'b1; @(negedge clk); clear_int = 1'b0;
                chk("sat_cleared", sat_flag, 0);
                chk("freq_kept_on_clear", frequency_df, 33554431);
                pd = '0; push(0); upd(); settle();
                chk("sat_stays_clear", sat_flag, 0);
                pd = -26'sd33554432; push(-33554432); upd(); settle();
                chk("sat_neg", sat_flag, 1);

                // Hold across one update, then clear coincident with an update
                do_reset(); set_coef(6, 13, 6, 13, 0); pd = 26'sd8192;
                push(129); upd();
                push(130); upd(); settle();
                repeat (10) @(negedge clk);
                chk("hold_freq", frequency_df, 130);
                push(131); upd(); settle();
                push(128); upd_clr(); settle();
                push(129); upd(); settle();

                // Reset in the middle of an update
                do_reset(); set_coef(6, 13, 6, 13, 1); pd = 26'sd8192;
                push(129); upd(); settle();
                chk("pre_rst_mode", mode_trk, 1);
                hold = 1'b0;
                while (ph != 0) @(negedge clk);
                @(negedge clk);
                rst = 1'b0; hold = 1'b1;
                @(negedge clk);
                chk("midrst_freq", frequency_df, 0);
                chk("midrst_valid", df_valid, 0);
                chk("midrst_mode", mode_trk, 0);
                chk("midrst_sat", sat_flag, 0);
                rst = 1'b1;
                push(129); upd(); settle();
                repeat (8) @(negedge clk);
                chk("queue_drained", exp_q.size(), 0);
            end
        join_any
        disable fork;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
